// File: rtl/pipe_mux_if.sv
// Handshake bundle for pipe_mux: producer side (in_*/sel) and consumer side (out_*).
// master = environment driving beats in and taking them out; slave = the mux itself.
interface pipe_mux_if #(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 3,
   parameter int SEL_W  = 2
) ();
   logic [WIDTH*NUM_IN-1:0] in_data;
   logic [SEL_W-1:0]        sel;
   logic                    in_valid;
   logic                    in_ready;
   logic [WIDTH-1:0]        out_data;
   logic                    out_err;
   logic                    out_valid;
   logic                    out_ready;

   modport master (
      output in_data, sel, in_valid, out_ready,
      input  in_ready, out_data, out_err, out_valid
   );

   modport slave (
      input  in_data, sel, in_valid, out_ready,
      output in_ready, out_data, out_err, out_valid
   );
endinterface

// File: rtl/pipe_mux.sv
// Channel-select mux feeding a two-entry (output + skid) pipeline register.
// Optional PIPE_MUX_ERR_CNT_EN adds a saturating count of illegal-select beats.
//
// state    | meaning
// EMPTY    | nothing held, out_valid=0
// ONE      | output register holds a beat
// FULL     | output and skid registers both hold beats, in_ready=0
module pipe_mux #(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 3,
   parameter int SEL_W  = 2
) (
   input  logic clk,
   input  logic reset,
   pipe_mux_if.slave bus
`ifdef PIPE_MUX_ERR_CNT_EN
   ,
   output logic [7:0] err_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_err_q, out_err_d;
   logic [WIDTH-1:0] skid_data_q, skid_data_d;
   logic             skid_err_q, skid_err_d;

   logic [WIDTH-1:0] mux_data;
   logic             mux_err;
   logic             in_ready;
   logic             out_valid;
   logic             accept;
   logic             pop;

   // in_ready depends only on registered state and reset, never on out_ready
   assign in_ready  = (state_q != ST_FULL) && !reset;
   assign out_valid = (state_q != ST_EMPTY);
   assign accept    = bus.in_valid && in_ready;
   assign pop       = out_valid && bus.out_ready;

   always_comb begin
      mux_data = '0;
      mux_err  = 1'b1;
      for (int k = 0; k < NUM_IN; k++) begin
         if (bus.sel == SEL_W'(k)) begin
            mux_data = bus.in_data[k*WIDTH +: WIDTH];
            mux_err  = 1'b0;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      out_data_d  = out_data_q;
      out_err_d   = out_err_q;
      skid_data_d = skid_data_q;
      skid_err_d  = skid_err_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               out_data_d = mux_data;
               out_err_d  = mux_err;
               state_d    = ST_ONE;
            end
         end
         ST_ONE: begin
            if (accept && !pop) begin
               skid_data_d = mux_data;
               skid_err_d  = mux_err;
               state_d     = ST_FULL;
            end else if (accept && pop) begin
               out_data_d = mux_data;
               out_err_d  = mux_err;
            end else if (pop) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (pop) begin
               out_data_d = skid_data_q;
               out_err_d  = skid_err_q;
               state_d    = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_EMPTY;
         out_data_q  <= '0;
         out_err_q   <= 1'b0;
         skid_data_q <= '0;
         skid_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_data_q  <= out_data_d;
         out_err_q   <= out_err_d;
         skid_data_q <= skid_data_d;
         skid_err_q  <= skid_err_d;
      end
   end

`ifdef PIPE_MUX_ERR_CNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (accept && mux_err && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_cnt_q <= 8'd0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt = err_cnt_q;
`endif

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_data  = out_data_q;
   assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_pipe_mux.sv
// Scoreboard bench for pipe_mux: accepted beats push an expected word, the output
// monitor pops and compares on every handshake; directed cases plus a random soak.
module tb_pipe_mux;

   localparam int WIDTH  = 32;
   localparam int NUM_IN = 3;
   localparam int SEL_W  = 2;
   localparam logic [95:0] CH = {32'h33333333, 32'h22222222, 32'h11111111};

   logic clk = 1'b0;
   logic reset = 1'b1;

   int errors = 0;
   int checks = 0;
   int pops   = 0;

   logic [32:0] exp_q[$];
   logic        held_valid = 1'b0;
   logic [32:0] held_word;

   pipe_mux_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) bus ();

`ifdef PIPE_MUX_ERR_CNT_EN
   logic [7:0] err_cnt;
   int         exp_cnt = 0;
`endif

   pipe_mux #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef PIPE_MUX_ERR_CNT_EN
      ,
      .err_cnt (err_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [32:0] ref_word(input logic [95:0] d, input logic [1:0] s);
      logic [32:0] w;
      case (s)
         2'd0:    w = {1'b0, d[31:0]};
         2'd1:    w = {1'b0, d[63:32]};
         2'd2:    w = {1'b0, d[95:64]};
         default: w = {1'b1, 32'h0};
      endcase
      return w;
   endfunction

   // input monitor: a beat seen with in_valid && in_ready here is taken at the next edge
   always @(negedge clk) begin
      if (!reset && bus.in_valid && bus.in_ready) begin
         exp_q.push_back(ref_word(bus.in_data, bus.sel));
      end
   end

   always @(negedge clk) begin
      if (!reset && bus.out_valid) begin
         if (held_valid) chk("stall_hold", {31'd0, bus.out_err, bus.out_data}, {31'd0, held_word});
         if (bus.out_ready) begin
            held_valid = 1'b0;
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 64'd1, 64'd0);
            end else begin
               chk("beat", {31'd0, bus.out_err, bus.out_data}, {31'd0, exp_q.pop_front()});
               pops++;
            end
         end else begin
            held_valid = 1'b1;
            held_word  = {bus.out_err, bus.out_data};
         end
      end else begin
         held_valid = 1'b0;
      end
   end

   always @(posedge reset) begin
      exp_q.delete();
      held_valid = 1'b0;
   end

`ifdef PIPE_MUX_ERR_CNT_EN
   always @(negedge clk) begin
      if (!reset) begin
         chk("err_cnt", {56'd0, err_cnt}, 64'(exp_cnt));
         if (bus.in_valid && bus.in_ready && bus.sel == 2'd3 && exp_cnt != 255) exp_cnt++;
      end
   end

   always @(posedge reset) exp_cnt = 0;
`endif

   task automatic drive(input logic v, input logic [1:0] s, input logic r, input logic [95:0] d);
      @(posedge clk);
      #1;
      bus.in_valid  = v;
      bus.sel       = s;
      bus.out_ready = r;
      bus.in_data   = d;
   endtask

   initial begin
      int base;
      bus.in_valid  = 1'b0;
      bus.sel       = 2'd0;
      bus.out_ready = 1'b0;
      bus.in_data   = CH;

      #2;
      chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
      chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("rst_out_data", {32'd0, bus.out_data}, 64'd0);
      chk("rst_out_err", {63'd0, bus.out_err}, 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

      // single beat, sel=1
      drive(1'b1, 2'd1, 1'b1, CH);
      drive(1'b0, 2'd0, 1'b1, CH);
      @(negedge clk);
      chk("single_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("single_data", {32'd0, bus.out_data}, 64'h22222222);
      @(negedge clk);
      chk("single_one_cycle", {63'd0, bus.out_valid}, 64'd0);

      // illegal select
      drive(1'b1, 2'd3, 1'b1, CH);
      drive(1'b0, 2'd0, 1'b1, CH);
      @(negedge clk);
      chk("illegal_err", {63'd0, bus.out_err}, 64'd1);
      chk("illegal_data", {32'd0, bus.out_data}, 64'd0);

      // fill to FULL with consumer stalled
      drive(1'b1, 2'd0, 1'b0, CH);
      drive(1'b1, 2'd2, 1'b0, CH);
      drive(1'b0, 2'd1, 1'b0, CH);
      @(negedge clk);
      chk("full_in_ready", {63'd0, bus.in_ready}, 64'd0);
      chk("full_hold_data", {32'd0, bus.out_data}, 64'h11111111);
      repeat (3) drive(1'b0, 2'd1, 1'b0, CH);
      drive(1'b0, 2'd0, 1'b1, CH);
      @(negedge clk);
      chk("drain_first", {32'd0, bus.out_data}, 64'h11111111);
      @(negedge clk);
      chk("drain_second", {32'd0, bus.out_data}, 64'h33333333);
      @(negedge clk);
      chk("drain_empty", {63'd0, bus.out_valid}, 64'd0);

      // streaming, one beat per cycle
      base = pops;
      for (int i = 0; i < 30; i++) begin
         drive(1'b1, 2'(i % 3), 1'b1, CH);
         @(negedge clk);
         chk("stream_in_ready", {63'd0, bus.in_ready}, 64'd1);
      end
      drive(1'b0, 2'd0, 1'b1, CH);
      repeat (3) @(negedge clk);
      chk("stream_count", 64'(pops - base), 64'd30);

      // reset while FULL, between edges
      drive(1'b1, 2'd0, 1'b0, CH);
      drive(1'b1, 2'd1, 1'b0, CH);
      drive(1'b0, 2'd0, 1'b0, CH);
      @(negedge clk);
      chk("pre_rst_full", {63'd0, bus.in_ready}, 64'd0);
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("async_rst_data", {32'd0, bus.out_data}, 64'd0);
      chk("async_rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rel_in_ready", {63'd0, bus.in_ready}, 64'd1);
      chk("rel_out_valid", {63'd0, bus.out_valid}, 64'd0);
      drive(1'b1, 2'd2, 1'b1, CH);
      drive(1'b0, 2'd0, 1'b1, CH);
      @(negedge clk);
      chk("after_rst_beat", {32'd0, bus.out_data}, 64'h33333333);

`ifdef PIPE_MUX_ERR_CNT_EN
      for (int i = 0; i < 300; i++) drive(1'b1, 2'd3, 1'b1, CH);
      drive(1'b0, 2'd0, 1'b1, CH);
      repeat (2) @(negedge clk);
      chk("err_cnt_sat", {56'd0, err_cnt}, 64'd255);
`endif

      // random soak against the scoreboard
      for (int i = 0; i < 10000; i++) begin
         drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               {$urandom, $urandom, $urandom});
      end
      drive(1'b0, 2'd0, 1'b1, CH);
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
      chk("drained", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_mux.md
PIPE_MUX -- requirements
Module: pipe_mux

Interface
REQ-001 Parameter WIDTH, default 32: data word width in bits, legal 1..64.
REQ-002 Parameter NUM_IN, default 3: number of input channels, legal 2..16.
REQ-003 Parameter SEL_W, default 2: select width; SHALL satisfy 2**SEL_W >= NUM_IN.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_data  input  WIDTH*NUM_IN  flattened channels; channel k at bits [k*WIDTH +: WIDTH].
REQ-007 sel  input  SEL_W  channel select, sampled with the beat.
REQ-008 in_valid  input  1  producer has a beat.
REQ-009 in_ready  output  1  block can accept a beat.
REQ-010 out_data  output  WIDTH  selected word.
REQ-011 out_err  output  1  beat carried an illegal select (sel >= NUM_IN).
REQ-012 out_valid  output  1  out_data/out_err hold a beat.
REQ-013 out_ready  input  1  consumer takes the beat.

Function
REQ-014 A beat SHALL be accepted on a rising edge when in_valid && in_ready; popped when out_valid && out_ready.
REQ-015 Accepted word SHALL be in_data[sel*WIDTH +: WIDTH] with out_err=0 when sel < NUM_IN; otherwise all-zero with out_err=1.
REQ-016 Storage SHALL be one output register plus one skid register; state machine EMPTY, ONE, FULL.
REQ-017 EMPTY: accept -> ONE (beat to output register); else stay.
REQ-018 ONE: accept && !pop -> FULL (beat to skid); accept && pop -> ONE (output register replaced by new beat); pop && !accept -> EMPTY; else stay.
REQ-019 FULL: pop -> ONE (skid moves to output register); else stay; no accept possible.
REQ-020 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL, and 0 while reset is asserted; no combinational path from out_ready to in_ready.
REQ-021 out_valid SHALL be 1 exactly in ONE and FULL.
REQ-022 Latency SHALL be one cycle: a beat accepted in EMPTY is presented with out_valid=1 after that edge.
REQ-023 out_data and out_err SHALL remain stable while out_valid && !out_ready.
REQ-024 Beats SHALL leave in acceptance order; none dropped or duplicated.
REQ-025 Sustained throughput SHALL be one beat per cycle when out_ready stays 1.
REQ-026 sel and in_data SHALL be ignored on cycles with no accept.

Reset
REQ-027 Asserting reset SHALL immediately force state EMPTY, out_valid=0, out_data=0, out_err=0, skid contents cleared, independent of clk.
REQ-028 Reset mid-transfer SHALL discard any held beats; first accept after deassertion starts from EMPTY.

Configuration
REQ-029 Macro PIPE_MUX_ERR_CNT_EN defined: SHALL add output err_cnt (8 bits), counting accepted beats with sel >= NUM_IN, saturating at 255, reset to 0.
REQ-030 Macro undefined: err_cnt port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-031 WIDTH=32, NUM_IN=3; channels 0x11111111/0x22222222/0x33333333, sel=1, single beat, out_ready=1 -> next cycle out_data=0x22222222, out_err=0, out_valid=1 for one cycle.
REQ-032 sel=3 (illegal) accepted -> out_data=0, out_err=1; with PIPE_MUX_ERR_CNT_EN err_cnt 0->1; 300 illegal beats -> err_cnt=255.
REQ-033 out_ready=0, beats sel=0 then sel=2 -> state FULL, in_ready=0, out_data=0x11111111 held; out_ready=1 -> 0x11111111 then 0x33333333 popped in order.
REQ-034 Continuous in_valid=1, out_ready=1, sel cycling 0,1,2 for 30 cycles -> 30 beats out, one per cycle, in_ready constantly 1.
REQ-035 Reset asserted mid-cycle while FULL -> out_valid=0, out_data=0 immediately without a clock edge; after release in_ready=1, state EMPTY.
REQ-036 Random in_valid/out_ready (50%) for 10000 cycles against a reference queue model -> zero order, data or out_err mismatches.
